scie_pipelined: RTL and testbench
=================================

// Module: scie_pipelined
// PURPOSE
//  Complex-valued FIR engine attached to the core as a SCIE custom-instruction unit.
//  - Custom instructions load tap coefficients, push input samples and request a filter output.
//  - The result is returned on io_rd_* one clock after the compute instruction.
//  - Data are complex numbers with 16-bit signed real and imaginary parts.
// PARAMETERS
//  NTAPS   8   number of FIR taps; tap index = io_rs2[$clog2(NTAPS)-1:0]
//  DW      16  width of each real/imag component (two's complement)
// PORTS
//  clock        in   1    single clock, rising edge
//  reset        in   1    synchronous, active-high
//  io_valid     in   1    instruction valid strobe
//  io_insn      in   32   instruction word; only opcode io_insn[6:0] decoded
//  io_rs1_real  in   16   signed real part of complex operand
//  io_rs1_imag  in   16   signed imaginary part of complex operand
//  io_rs2       in   32   tap index for coefficient load
//  io_rd_real   out  16   signed real part of last filter result
//  io_rd_imag   out  16   signed imaginary part of last filter result
// BEHAVIOUR
//  - Reset (sync, active-high): clear all coef[i], all x[i] and io_rd_* to 0.
//  - Nothing changes when io_valid=0. Any other opcode is ignored.
//  - 0x0B (SETCOEF): coef[io_rs2 idx] <= rs1. Upper io_rs2 bits are ignored.
//  - 0x2B (PUSH): x[i] <= x[i-1] for i>0, and x[0] <= rs1.
//    The oldest sample is dropped. x[0] is the newest sample.
//  - 0x5B (COMPUTE): y = sum_i coef[i]*x[i] (complex multiply), registered to io_rd_* at the same edge.
//    Latency 1 clock: visible immediately after the capturing edge.
//    COMPUTE does not shift in a sample. It uses state before this edge.
//  - io_rd_* hold their value until the next COMPUTE or reset.
//  - Complex product: re = a.re*b.re - a.im*b.im, im = a.re*b.im + a.im*b.re.
//    Products use a full 32-bit signed width.
//    Accumulate in >= 32+$clog2(NTAPS)+1 bits.
//    Output = low 16 bits of the sum (wrap, no saturation).
//  - Back-to-back instructions on consecutive cycles must each take effect, with no stall.
//  - SETCOEF to a tap on the cycle before COMPUTE must be reflected in that COMPUTE.
//  - Reset asserted mid-sequence wins over any instruction that cycle.
// STRUCTURE
//  - Shared package scie_pkg holds:
//    - opcode constants OP_SETCOEF=7'h0B, OP_PUSH=7'h2B, OP_COMPUTE=7'h5B;
//    - typedef complex_t {logic signed [15:0] re, im;};
//    - the DW/NTAPS defaults.
//  - One sub-module, complex_mul:
//    - input: two complex_t;
//    - output: 32-bit signed re/im products, combinational.
//    - Instantiate it NTAPS times and sum the outputs in an adder tree.
//  - Top level holds:
//    - the coefficient register file;
//    - the sample shift register;
//    - the opcode decode;
//    - the io_rd output register.
// TESTING
//  1. Reset, then COMPUTE -> io_rd = (0,0).
//  2. Load taps, then push sample and compute (main directed case):
//     - SETCOEF idx0=(-34,-15), idx1=(24,37), idx2=(13,-4);
//     - PUSH (-46,-21);
//     - one idle cycle with valid=0;
//     - COMPUTE -> next cycle io_rd = (1249,1404).
//  3. Continue from 2:
//     - PUSH (1,0);
//     - COMPUTE -> io_rd = (-361,-2221).
//  4. Wrap-around:
//     - coef0=(200,0), PUSH (200,0), COMPUTE;
//     - 40000 truncates to 16 bits -> io_rd = (-25536,0).
//  5. Gated strobe: io_valid=0 with opcode 0x0B/0x2B/0x5B present -> no state change and io_rd unchanged.
//  6. Reset after step 2, then COMPUTE -> (0,0).
//     Unknown opcode 0x33 with valid=1 -> ignored.

Source files
------------

// File: rtl/scie_pkg.sv
// Shared definitions for the SCIE complex FIR engine: opcodes, complex sample type and size defaults.
package scie_pkg;

  localparam int DW_DEF    = 16;
  localparam int NTAPS_DEF = 8;

  localparam logic [6:0] OP_SETCOEF = 7'h0B;
  localparam logic [6:0] OP_PUSH    = 7'h2B;
  localparam logic [6:0] OP_COMPUTE = 7'h5B;

  typedef struct packed {
    logic signed [15:0] re;
    logic signed [15:0] im;
  } complex_t;

endpackage

// File: rtl/complex_mul.sv
// Combinational complex multiplier producing full-width 32-bit signed real/imag products.
module complex_mul
  import scie_pkg::*;
(
  input  complex_t           a,
  input  complex_t           b,
  output logic signed [31:0] re,
  output logic signed [31:0] im
);

  logic signed [31:0] rr, ii, ri, ir;

  assign rr = a.re * b.re;
  assign ii = a.im * b.im;
  assign ri = a.re * b.im;
  assign ir = a.im * b.re;

  assign re = rr - ii;
  assign im = ri + ir;

endmodule

// File: rtl/scie_pipelined.sv
// SCIE custom-instruction complex FIR: coefficient file, sample shift register and a
// single-cycle multiply/adder-tree whose wrapped result is registered onto io_rd_*.
module scie_pipelined
  import scie_pkg::*;
#(
  parameter int NTAPS = NTAPS_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 io_valid,
  input  logic [31:0]          io_insn,
  input  logic signed [DW-1:0] io_rs1_real,
  input  logic signed [DW-1:0] io_rs1_imag,
  input  logic [31:0]          io_rs2,
  output logic signed [DW-1:0] io_rd_real,
  output logic signed [DW-1:0] io_rd_imag
);

  localparam int IDX_W = $clog2(NTAPS);
  localparam int ACC_W = 2 * DW + IDX_W + 1;
  localparam int NODES = 2 * NTAPS - 1;

  complex_t coef [NTAPS];
  complex_t x    [NTAPS];
  complex_t rs1;

  logic [6:0]       opcode;
  logic [IDX_W-1:0] idx;
  logic             unused_bits;

  assign rs1         = '{re: io_rs1_real, im: io_rs1_imag};
  assign opcode      = io_insn[6:0];
  assign idx         = io_rs2[IDX_W-1:0];
  assign unused_bits = ^{io_insn[31:7], io_rs2[31:IDX_W]};

  logic signed [ACC_W-1:0] node_re [NODES];
  logic signed [ACC_W-1:0] node_im [NODES];

  // Products sit in the heap leaves; each internal node sums its two children, root is node 0.
  for (genvar t = 0; t < NTAPS; t++) begin : g_tap
    logic signed [31:0] p_re, p_im;

    complex_mul u_mul (
      .a  (coef[t]),
      .b  (x[t]),
      .re (p_re),
      .im (p_im)
    );

    assign node_re[NTAPS-1+t] = {{(ACC_W-32){p_re[31]}}, p_re};
    assign node_im[NTAPS-1+t] = {{(ACC_W-32){p_im[31]}}, p_im};
  end

  for (genvar n = 0; n < NTAPS - 1; n++) begin : g_tree
    assign node_re[n] = node_re[2*n+1] + node_re[2*n+2];
    assign node_im[n] = node_im[2*n+1] + node_im[2*n+2];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NTAPS; i++) begin
        coef[i] <= '0;
        x[i]    <= '0;
      end
      io_rd_real <= '0;
      io_rd_imag <= '0;
    end else if (io_valid) begin
      case (opcode)
        OP_SETCOEF: coef[idx] <= rs1;
        OP_PUSH: begin
          for (int i = 1; i < NTAPS; i++) x[i] <= x[i-1];
          x[0] <= rs1;
        end
        OP_COMPUTE: begin
          io_rd_real <= node_re[0][DW-1:0];
          io_rd_imag <= node_im[0][DW-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_scie_pipelined.sv
// Directed bench for scie_pipelined with a reference model feeding a scoreboard queue.
module tb_scie_pipelined;
  import scie_pkg::*;

  logic               clock = 1'b0;
  logic               reset;
  logic               io_valid;
  logic [31:0]        io_insn;
  logic signed [15:0] io_rs1_real;
  logic signed [15:0] io_rs1_imag;
  logic [31:0]        io_rs2;
  logic signed [15:0] io_rd_real;
  logic signed [15:0] io_rd_imag;

  int checks = 0;
  int errors = 0;

  logic signed [15:0] m_cr [8];
  logic signed [15:0] m_ci [8];
  logic signed [15:0] m_xr [8];
  logic signed [15:0] m_xi [8];
  logic signed [15:0] exp_re, exp_im;
  logic [31:0]        sb_q [$];

  scie_pipelined dut (
    .clock       (clock),
    .reset       (reset),
    .io_valid    (io_valid),
    .io_insn     (io_insn),
    .io_rs1_real (io_rs1_real),
    .io_rs1_imag (io_rs1_imag),
    .io_rs2      (io_rs2),
    .io_rd_real  (io_rd_real),
    .io_rd_imag  (io_rd_imag)
  );

  always #5 clock = ~clock;

  task automatic model_clear();
    for (int i = 0; i < 8; i++) begin
      m_cr[i] = 0; m_ci[i] = 0; m_xr[i] = 0; m_xi[i] = 0;
    end
    exp_re = 0;
    exp_im = 0;
  endtask

  task automatic model_compute();
    longint sr, si;
    sr = 0;
    si = 0;
    for (int i = 0; i < 8; i++) begin
      sr += longint'(m_cr[i]) * longint'(m_xr[i]) - longint'(m_ci[i]) * longint'(m_xi[i]);
      si += longint'(m_cr[i]) * longint'(m_xi[i]) + longint'(m_ci[i]) * longint'(m_xr[i]);
    end
    exp_re = sr[15:0];
    exp_im = si[15:0];
  endtask

  task automatic drive(input logic v, input logic [6:0] op, input int re, input int im,
                       input logic [31:0] rs2);
    io_valid    = v;
    io_insn     = {25'h1A5_5A5A, op};
    io_rs1_real = re[15:0];
    io_rs1_imag = im[15:0];
    io_rs2      = rs2;
  endtask

  task automatic pop_check(input string tag);
    logic [31:0] exp, got;
    exp = sb_q.pop_front();
    got = {io_rd_real, io_rd_imag};
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got (%0d,%0d) want (%0d,%0d)", tag, $signed(got[31:16]),
             $signed(got[15:0]), $signed(exp[31:16]), $signed(exp[15:0]));
    end
  endtask

  task automatic step(input logic v, input logic [6:0] op, input int re, input int im,
                      input logic [31:0] rs2, input string tag);
    drive(v, op, re, im, rs2);
    if (v) begin
      case (op)
        OP_SETCOEF: begin
          m_cr[rs2[2:0]] = re[15:0];
          m_ci[rs2[2:0]] = im[15:0];
        end
        OP_PUSH: begin
          for (int i = 7; i > 0; i--) begin
            m_xr[i] = m_xr[i-1];
            m_xi[i] = m_xi[i-1];
          end
          m_xr[0] = re[15:0];
          m_xi[0] = im[15:0];
        end
        OP_COMPUTE: model_compute();
        default: ;
      endcase
    end
    sb_q.push_back({exp_re, exp_im});
    @(posedge clock);
    #1;
    pop_check(tag);
    io_valid = 1'b0;
  endtask

  task automatic do_reset(input logic v, input logic [6:0] op, input string tag);
    drive(v, op, 77, -77, 32'h0);
    reset = 1'b1;
    model_clear();
    sb_q.push_back({exp_re, exp_im});
    @(posedge clock);
    #1;
    pop_check(tag);
    reset    = 1'b0;
    io_valid = 1'b0;
  endtask

  task automatic check_lit(input string tag, input int re, input int im);
    logic signed [15:0] wr, wi;
    wr = re[15:0];
    wi = im[15:0];
    checks++;
    assert (io_rd_real === wr && io_rd_imag === wi) else begin
      errors++;
      $error("FAIL %s got (%0d,%0d) want (%0d,%0d)", tag, io_rd_real, io_rd_imag, wr, wi);
    end
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, 7'h00, 0, 0, 32'h0);
    model_clear();
    @(negedge clock);

    do_reset(1'b0, 7'h00, "reset");
    step(1, OP_COMPUTE, 0, 0, 0, "reset_compute");
    check_lit("reset_compute_lit", 0, 0);

    step(1, OP_SETCOEF, -34, -15, 32'h0, "set0");
    step(1, OP_SETCOEF,  24,  37, 32'hFFFF_FFF9, "set1_hi_bits");
    step(1, OP_SETCOEF,  13,  -4, 32'h0000_0002, "set2");
    step(1, OP_PUSH,    -46, -21, 32'h0, "push_a");
    step(0, 7'h00, 0, 0, 32'h0, "idle");
    step(1, OP_COMPUTE, 0, 0, 0, "compute_main");
    check_lit("compute_main_lit", 1249, 1404);

    step(1, OP_PUSH, 1, 0, 32'h0, "push_b");
    step(1, OP_COMPUTE, 0, 0, 0, "compute_second");
    check_lit("compute_second_lit", -361, -2221);

    step(0, OP_SETCOEF, 999, 999, 32'h0, "gated_set");
    step(0, OP_PUSH, 555, -555, 32'h0, "gated_push");
    step(0, OP_COMPUTE, 0, 0, 0, "gated_compute");
    check_lit("gated_hold_lit", -361, -2221);
    step(1, 7'h33, 123, 456, 32'h0, "unknown_op");
    step(1, OP_COMPUTE, 0, 0, 0, "compute_after_gated");
    check_lit("state_unchanged_lit", -361, -2221);

    step(1, OP_SETCOEF, 0, 0, 32'h1, "clr1");
    step(1, OP_SETCOEF, 0, 0, 32'h2, "clr2");
    step(1, OP_SETCOEF, 200, 0, 32'h0, "set_wrap");
    step(1, OP_PUSH, 200, 0, 32'h0, "push_wrap");
    step(1, OP_COMPUTE, 0, 0, 0, "compute_wrap");
    check_lit("compute_wrap_lit", -25536, 0);

    for (int i = 0; i < 8; i++) step(1, OP_PUSH, i * 3 - 7, -i, 32'h0, "b2b_push");
    for (int i = 0; i < 8; i++) step(1, OP_SETCOEF, i + 1, 2 - i, i, "b2b_set");
    step(1, OP_SETCOEF, -300, 41, 32'h5, "set_before_compute");
    step(1, OP_COMPUTE, 0, 0, 0, "compute_b2b");
    step(1, OP_PUSH, 1000, -2000, 32'h0, "push_after");
    step(1, OP_COMPUTE, 0, 0, 0, "compute_b2b_2");

    do_reset(1'b1, OP_COMPUTE, "reset_wins");
    check_lit("reset_wins_lit", 0, 0);
    step(1, OP_COMPUTE, 0, 0, 0, "compute_after_reset");
    check_lit("compute_after_reset_lit", 0, 0);
    step(1, OP_SETCOEF, 3, 5, 32'h0, "post_set");
    step(1, OP_PUSH, 2, 0, 32'h0, "post_push");
    step(1, 7'h33, 100, 100, 32'h0, "post_unknown");
    step(1, OP_COMPUTE, 0, 0, 0, "post_compute");
    check_lit("post_compute_lit", 6, 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
